// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Define UART_ARB_TIMEOUT_EN to revoke a grant whose owner idles for TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   timeout_pulse
);

  localparam int unsigned IDX_W = (NUM_REQ > 2) ? 2 : 1;

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("uart_tx_arbiter: NUM_REQ or TIMEOUT out of range");
  end

  typedef enum logic [1:0] {IDLE, LOCKED, WAIT_ACK, WAIT_DONE} state_t;

  state_t             state, state_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [IDX_W-1:0]   last_owner, last_owner_d;
  logic [7:0]         tx_data_d;
  logic               tx_start_d;
  logic               release_pend, release_pend_d;

  logic [7:0]         owner_data;
  logic               owner_last;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic               transfer;

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] idle_cnt, idle_cnt_d;
  logic        timeout_pulse_d;
  logic        owner_valid;
`endif

  // Requester index base+off wrapped into 0..NUM_REQ-1 (off never exceeds NUM_REQ)
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                              input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  assign req_ready = (state == LOCKED && !tx_busy) ? grant : '0;
  assign transfer  = |(req_valid & req_ready);

  // Owner's request fields, selected by the one-hot grant
  always_comb begin
    owner_data = 8'h00;
    owner_last = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    owner_valid = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        owner_data = req_data[8*i +: 8];
        owner_last = req_last[i];
`ifdef UART_ARB_TIMEOUT_EN
        owner_valid = req_valid[i];
`endif
      end
    end
  end

  // First valid requester searching upward from last_owner+1
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = rr_idx(last_owner, off);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d        = state;
    grant_d        = grant;
    last_owner_d   = last_owner;
    tx_data_d      = tx_data;
    tx_start_d     = 1'b0;
    release_pend_d = release_pend;
`ifdef UART_ARB_TIMEOUT_EN
    idle_cnt_d      = idle_cnt;
    timeout_pulse_d = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_d      = NUM_REQ'(1) << pick_idx;
          last_owner_d = pick_idx;
          state_d      = LOCKED;
`ifdef UART_ARB_TIMEOUT_EN
          idle_cnt_d   = '0;
`endif
        end
      end
      LOCKED: begin
        if (transfer) begin
          tx_data_d      = owner_data;
          tx_start_d     = 1'b1;
          release_pend_d = owner_last;
          state_d        = WAIT_ACK;
`ifdef UART_ARB_TIMEOUT_EN
          idle_cnt_d     = '0;
        end else if (!owner_valid) begin
          if (idle_cnt == TIMEOUT_LAST) begin
            grant_d         = '0;
            timeout_pulse_d = 1'b1;
            state_d         = IDLE;
            idle_cnt_d      = '0;
          end else begin
            idle_cnt_d = idle_cnt + 16'd1;
          end
        end else begin
          idle_cnt_d = '0;
`endif
        end
      end
      WAIT_ACK: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (release_pend) begin
            grant_d        = '0;
            release_pend_d = 1'b0;
            state_d        = IDLE;
          end else begin
            state_d = LOCKED;
`ifdef UART_ARB_TIMEOUT_EN
            idle_cnt_d = '0;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      grant        <= '0;
      last_owner   <= IDX_W'(NUM_REQ - 1);
      tx_data      <= 8'h00;
      tx_start     <= 1'b0;
      release_pend <= 1'b0;
    end else begin
      state        <= state_d;
      grant        <= grant_d;
      last_owner   <= last_owner_d;
      tx_data      <= tx_data_d;
      tx_start     <= tx_start_d;
      release_pend <= release_pend_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      idle_cnt      <= idle_cnt_d;
      timeout_pulse <= timeout_pulse_d;
    end
  end
`else
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued requester streams, a UART busy model,
// and per-byte / per-cycle checks of ordering, locking and release timing.
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ = 2;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TIMEOUT = 10;
`else
  localparam int unsigned TIMEOUT = 255;
`endif

  typedef struct { logic [7:0] data; logic last; } item_t;
  typedef struct { logic [7:0] data; logic last; int src; } exp_t;

  logic                 clk;
  logic                 reset_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic                 timeout_pulse;

  item_t              rq[NUM_REQ][$];
  exp_t               exp_q[$];
  logic [NUM_REQ-1:0] glog[$];

  int n_checks = 0;
  int n_errors = 0;
  int busy_len = 20;
  int start_cnt = 0;
  int drop_cnt = 0;
  int tp_count = 0;
  int post = 0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .timeout_pulse(timeout_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] onehot(input int src);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[src] = 1'b1;
    return v;
  endfunction

  task automatic offer(input int src, input logic [7:0] d, input logic l);
    item_t it;
    it.data = d;
    it.last = l;
    rq[src].push_back(it);
  endtask

  task automatic expect_byte(input int src, input logic [7:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    e.src  = src;
    exp_q.push_back(e);
  endtask

  task automatic send(input int src, input logic [7:0] d, input logic l);
    offer(src, d, l);
    expect_byte(src, d, l);
  endtask

  // Requester drivers: present queue heads, pop on a handshake seen before the edge
  initial begin
    logic [NUM_REQ-1:0] hs;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs[i] && reset_n && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = rq[i][0].data;
          req_last[i]        = rq[i][0].last;
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  // UART core model: busy rises one cycle after tx_start and lasts busy_len cycles
  initial begin
    int served;
    int cnt;
    served  = 0;
    cnt     = 0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (start_cnt != served) begin
        served  = start_cnt;
        tx_busy = 1'b1;
        cnt     = busy_len;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          tx_busy = 1'b0;
          drop_cnt++;
        end
      end
    end
  end

  // Output monitor and scoreboard consumer
  initial begin
    exp_t               e;
    logic               start_prev;
    logic               tp_prev;
    logic [NUM_REQ-1:0] gprev;
    int                 seen_drop;
    bit                 stale;
    int                 cur_src;
    bit                 cur_last;
    start_prev = 1'b0;
    tp_prev    = 1'b0;
    gprev      = '0;
    seen_drop  = 0;
    stale      = 1'b0;
    cur_src    = 0;
    cur_last   = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stale      = tx_busy;
        post       = 0;
        gprev      = '0;
        start_prev = 1'b0;
        tp_prev    = 1'b0;
      end else begin
        if (post == 1) begin
          if (cur_last) check("grant_release", 32'(grant), 32'(0));
          else          check("ready_next", 32'(req_ready), 32'(onehot(cur_src)));
          post = 0;
        end
        if (drop_cnt != seen_drop) begin
          if (stale) stale = 1'b0;
          else begin
            check("grant_hold", 32'(grant), 32'(onehot(cur_src)));
            post = 1;
          end
        end
        if (tx_start) begin
          check("start_width", 32'(start_prev), 32'(0));
          check("start_in_busy", 32'(tx_busy), 32'(0));
          if (exp_q.size() == 0) begin
            check("unexpected_tx", 32'(tx_data), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("tx_data", 32'(tx_data), 32'(e.data));
            check("tx_grant", 32'(grant), 32'(onehot(e.src)));
            cur_src  = e.src;
            cur_last = e.last;
          end
          start_cnt++;
        end
        if (tx_busy) check("ready_in_busy", 32'(req_ready), 32'(0));
        check("ready_owner", 32'(req_ready & ~grant), 32'(0));
        check("grant_onehot", 32'($countones(grant) <= 1), 32'(1));
        if (timeout_pulse) begin
          tp_count++;
          check("tp_width", 32'(tp_prev), 32'(0));
        end
        if (grant != '0 && gprev == '0) glog.push_back(grant);
        gprev      = grant;
        start_prev = tx_start;
        tp_prev    = timeout_pulse;
      end
      seen_drop = drop_cnt;
    end
  end

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(negedge clk);
      if (rq[0].size() == 0 && rq[1].size() == 0 && exp_q.size() == 0 &&
          !tx_busy && grant == '0 && post == 0) done = 1'b1;
    end
    if (!done) check(tag, 32'(0), 32'(1));
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_grant"}, 32'(grant), 32'(0));
    check({pfx, "_ready"}, 32'(req_ready), 32'(0));
    check({pfx, "_tx_data"}, 32'(tx_data), 32'(0));
    check({pfx, "_tx_start"}, 32'(tx_start), 32'(0));
    check({pfx, "_tp"}, 32'(timeout_pulse), 32'(0));
  endtask

  initial begin
    bit seen;
    int tp_base;
    reset_n = 1'b0;
    #1;
    check_reset_values("rst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Single byte
    send(0, 8'h41, 1'b1);
    wait_idle("t1_idle");

    // Packet lock against a waiting requester
    do_reset();
    send(0, 8'h48, 1'b0);
    send(0, 8'h69, 1'b1);
    send(1, 8'h5A, 1'b1);
    wait_idle("t2_idle");

    // Round-robin between continuous single-byte packets
    do_reset();
    glog.delete();
    for (int n = 0; n < 4; n++) begin
      send(0, 8'(8'hA0 + n), 1'b1);
      send(1, 8'(8'hB0 + n), 1'b1);
    end
    wait_idle("t3_idle");
    check("rr_count", 32'(glog.size()), 32'(8));
    for (int k = 0; k < glog.size(); k++)
      check("rr_order", 32'(glog[k]), (k % 2 == 0) ? 32'(1) : 32'(2));

    // Long busy stall inside a packet
    busy_len = 100;
    send(0, 8'hC1, 1'b0);
    send(0, 8'hC2, 1'b1);
    wait_idle("t4_idle");
    busy_len = 20;

    do_reset();
    tp_base = tp_count;
`ifdef UART_ARB_TIMEOUT_EN
    // Owner goes silent mid-packet; grant is revoked and requester 1 served
    send(0, 8'hF0, 1'b0);
    send(1, 8'hF1, 1'b1);
    wait_idle("t5_idle");
    check("tp_count", 32'(tp_count - tp_base), 32'(1));
`else
    // Owner goes silent mid-packet; grant is held until its last byte
    offer(0, 8'hD0, 1'b0);
    expect_byte(0, 8'hD0, 1'b0);
    offer(1, 8'hE0, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !tx_busy && post == 0) seen = 1'b1;
    end
    if (!seen) check("t5_d0_wait", 32'(0), 32'(1));
    repeat (60) @(negedge clk);
    check("lock_hold", 32'(grant), 32'(1));
    offer(0, 8'hD1, 1'b1);
    expect_byte(0, 8'hD1, 1'b1);
    expect_byte(1, 8'hE0, 1'b1);
    wait_idle("t5_idle");
    check("tp_none", 32'(tp_count - tp_base), 32'(0));
`endif

    // Asynchronous reset while a byte is on the wire
    send(0, 8'h11, 1'b0);
    send(0, 8'h22, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (tx_busy) seen = 1'b1;
    end
    if (!seen) check("t6_busy_wait", 32'(0), 32'(1));
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    glog.delete();
    send(0, 8'h33, 1'b1);
    send(1, 8'h44, 1'b1);
    wait_idle("t6_idle");
    check("post_rst_grants", 32'(glog.size()), 32'(2));
    check("post_rst_first", 32'(glog.size() > 0 ? glog[0] : '0), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
